// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier and its result collector.
package booth_pkg;

    // Operand / export bus width shared with the multiplier.
    localparam int unsigned BOOTH_WIDTH   = 8;
    // Default number of buffered products in the collector.
    localparam int unsigned COLLECT_DEPTH = 4;

    // Half-word assembly state.
    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } collect_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DW-1:0]            i_data,
    output logic [DW-1:0]            o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage write; contents need no reset since reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/booth_result_collector.sv
// Reassembles high/low product halves from the multiplier export bus and buffers them.
module booth_result_collector
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = BOOTH_WIDTH,
    parameter int unsigned DEPTH = COLLECT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done,
    input  logic                     selL,
    input  logic                     selR,
    input  logic [WIDTH-1:0]         dataBus,
    input  logic                     clrErr,
    input  logic                     outReady,
    output logic                     outValid,
    output logic [2*WIDTH-1:0]       outProduct,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     protoErr
);

    collect_state_e     r_state;
    logic [WIDTH-1:0]   r_hi;
    logic               r_overflow;
    logic               r_proto_err;

    logic               w_hi_ev;
    logic               w_lo_ev;
    logic               w_bad_sel;
    logic               w_push_req;
    logic               w_proto_set;
    logic               w_ovf_set;
    logic               w_empty;
    logic [2*WIDTH-1:0] w_head;

    assign w_hi_ev     = done & selL & ~selR;
    assign w_lo_ev     = done & selR & ~selL;
    assign w_bad_sel   = done & ~(selL ^ selR);
    assign w_push_req  = (r_state == WAIT_LO) & w_lo_ev;
    assign w_proto_set = w_bad_sel
                       | ((r_state == WAIT_HI) & w_lo_ev)
                       | ((r_state == WAIT_LO) & w_hi_ev);
    // A completed product is lost only when no pop frees a slot this cycle.
    assign w_ovf_set   = w_push_req & full & ~(outReady & ~w_empty);

    // Assembly FSM; a high half seen while waiting for the low half restarts the word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WAIT_HI;
            r_hi    <= '0;
        end else begin
            if (w_hi_ev) begin
                r_hi    <= dataBus;
                r_state <= WAIT_LO;
            end else if (w_push_req) begin
                r_state <= WAIT_HI;
            end
        end
    end

    // Sticky error flags; a new set condition wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_set   | (r_overflow  & ~clrErr);
            r_proto_err <= w_proto_set | (r_proto_err & ~clrErr);
        end
    end

    sync_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_req),
        .i_pop   (outReady),
        .i_data  ({r_hi, dataBus}),
        .o_data  (w_head),
        .o_count (count),
        .o_full  (full),
        .o_empty (w_empty)
    );

    assign outValid   = ~w_empty;
    assign outProduct = outValid ? w_head : '0;
    assign overflow   = r_overflow;
    assign protoErr   = r_proto_err;

endmodule

// File: tb/tb_booth_result_collector.sv
// Directed and randomized checks of booth_result_collector against a queue model.
module tb_booth_result_collector;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = $clog2(D) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             done;
    logic             selL;
    logic             selR;
    logic [W-1:0]     dataBus;
    logic             clrErr;
    logic             outReady;
    logic             outValid;
    logic [2*W-1:0]   outProduct;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             protoErr;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of buffered products, pending high half, sticky flags.
    logic [2*W-1:0] m_q[$];
    bit             m_have_hi;
    logic [W-1:0]   m_hi;
    bit             m_ovf;
    bit             m_perr;

    booth_result_collector #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .done       (done),
        .selL       (selL),
        .selR       (selR),
        .dataBus    (dataBus),
        .clrErr     (clrErr),
        .outReady   (outReady),
        .outValid   (outValid),
        .outProduct (outProduct),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .protoErr   (protoErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [2*W-1:0] head;
        head = (m_q.size() != 0) ? m_q[0] : '0;
        chk("outValid",   32'(outValid),   32'(m_q.size() != 0));
        chk("outProduct", 32'(outProduct), 32'(head));
        chk("count",      32'(count),      32'(m_q.size()));
        chk("full",       32'(full),       32'(m_q.size() == D));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("protoErr",   32'(protoErr),   32'(m_perr));
        chk("count_max",  32'(count <= CW'(D)), 32'(1));
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model.
    task automatic step(input logic d, input logic l, input logic r,
                        input logic [W-1:0] bus, input logic rdy, input logic clr);
        bit             pop;
        bit             push;
        bit             perr_set;
        bit             ovf_set;
        int             size_before;
        logic [2*W-1:0] prod;
        done = d; selL = l; selR = r; dataBus = bus; outReady = rdy; clrErr = clr;
        #1;
        check_model();
        pop = (m_q.size() != 0) && rdy;
        push = 0; perr_set = 0; ovf_set = 0; prod = '0;
        if (d) begin
            if (l == r) begin
                perr_set = 1;
            end else if (l) begin
                if (m_have_hi) perr_set = 1;
                m_hi      = bus;
                m_have_hi = 1;
            end else begin
                if (!m_have_hi) begin
                    perr_set = 1;
                end else begin
                    push      = 1;
                    prod      = {m_hi, bus};
                    m_have_hi = 0;
                end
            end
        end
        size_before = m_q.size();
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (size_before < D || pop) m_q.push_back(prod);
            else ovf_set = 1;
        end
        if (clr) begin
            m_ovf  = 0;
            m_perr = 0;
        end
        if (ovf_set)  m_ovf  = 1;
        if (perr_set) m_perr = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, '0, rdy, 1'b0);
    endtask

    task automatic export_word(input logic [2*W-1:0] p, input logic rdy_hi, input logic rdy_lo);
        step(1'b1, 1'b1, 1'b0, p[2*W-1:W], rdy_hi, 1'b0);
        step(1'b1, 1'b0, 1'b1, p[W-1:0],   rdy_lo, 1'b0);
    endtask

    task automatic do_reset();
        done = 0; selL = 0; selR = 0; dataBus = '0; clrErr = 0; outReady = 0;
        rst = 1'b0;
        #2;
        m_q.delete();
        m_have_hi = 0; m_hi = '0; m_ovf = 0; m_perr = 0;
        check_model();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_expect(input string tag, input logic [2*W-1:0] exp);
        chk(tag, 32'(outProduct), 32'(exp));
        idle(1'b1);
    endtask

    initial begin
        done = 0; selL = 0; selR = 0; dataBus = '0; clrErr = 0; outReady = 0;
        rst = 1'b1;
        #3;
        do_reset();

        // Basic export: -15 reassembled from FF / F1.
        export_word(16'hFFF1, 1'b1, 1'b1);
        chk("basic_valid", 32'(outValid),   32'(1));
        chk("basic_prod",  32'(outProduct), 32'h0000_FFF1);
        chk("basic_perr",  32'(protoErr),   32'(0));
        chk("basic_ovf",   32'(overflow),   32'(0));
        idle(1'b1);

        // Fill and overflow with back-pressure.
        for (int i = 1; i <= 5; i++) export_word(16'(i), 1'b0, 1'b0);
        chk("fill_full",  32'(full),     32'(1));
        chk("fill_count", 32'(count),    32'(4));
        chk("fill_ovf",   32'(overflow), 32'(1));
        for (int i = 1; i <= 4; i++) drain_expect("fill_drain", 16'(i));
        chk("fill_empty", 32'(outValid), 32'(0));
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'(0));

        // Full FIFO with a pop in the low-half cycle: push accepted.
        for (int i = 1; i <= 4; i++) export_word(16'h0010 + 16'(i), 1'b0, 1'b0);
        export_word(16'h0015, 1'b0, 1'b1);
        chk("fp_count", 32'(count),    32'(4));
        chk("fp_ovf",   32'(overflow), 32'(0));
        drain_expect("fp_drain", 16'h0012);
        drain_expect("fp_drain", 16'h0013);
        drain_expect("fp_drain", 16'h0014);
        drain_expect("fp_drain", 16'h0015);

        // Protocol errors.
        step(1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        chk("lo_alone_perr",  32'(protoErr), 32'(1));
        chk("lo_alone_valid", 32'(outValid), 32'(0));
        step(1'b1, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h34, 1'b0, 1'b0);
        chk("restart_prod", 32'(outProduct), 32'h0000_1234);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("clr_perr", 32'(protoErr), 32'(0));
        step(1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h98, 1'b1, 1'b1);
        chk("both_none_perr", 32'(protoErr), 32'(1));
        step(1'b0, 1'b1, 1'b1, 8'h97, 1'b1, 1'b1);
        chk("nodone_clear", 32'(protoErr), 32'(0));

        // Reset between high and low halves discards the partial word.
        step(1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        do_reset();
        export_word(16'h0A0B, 1'b0, 1'b0);
        chk("rst_mid_prod",  32'(outProduct), 32'h0000_0A0B);
        chk("rst_mid_count", 32'(count),      32'(1));
        chk("rst_mid_perr",  32'(protoErr),   32'(0));
        chk("rst_mid_ovf",   32'(overflow),   32'(0));
        idle(1'b1);

        // Random products with random back-pressure and stray selects.
        for (int n = 0; n < 200; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            end
            export_word(16'($urandom), 1'($urandom), 1'($urandom));
        end
        for (int i = 0; i < D + 2; i++) idle(1'b1);
        chk("final_empty", 32'(outValid), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/booth_result_collector.md
# booth_result_collector

Downstream consumer of the Booth multiplier controller/datapath. The multiplier exports each 2·WIDTH-bit two's-complement product over a WIDTH-bit bus in two consecutive `done` cycles: high half with `selL`, then low half with `selR`. This block reassembles the halves into one product word and buffers it in a small FIFO. It presents results to the next stage with a valid/ready handshake and raises `full` so the upstream `start` can be gated.

## Interface
- `WIDTH`, 8: multiplier operand width and export bus width.
- `DEPTH`, 4: FIFO entries; a power of two, ≥ 2.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `done`  in  1  export strobe from the multiplier controller.
- `selL`  in  1  bus carries the high half (qualified by `done`).
- `selR`  in  1  bus carries the low half (qualified by `done`).
- `dataBus`  in  WIDTH  export bus from the multiplier datapath.
- `clrErr`  in  1  synchronous clear of the sticky error flags.
- `outReady`  in  1  downstream accepts the head entry.
- `outValid`  out  1  FIFO non-empty.
- `outProduct`  out  2·WIDTH  head entry; forced to 0 when `outValid`=0.
- `full`  out  1  FIFO holds DEPTH entries.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: a completed product was dropped because the FIFO was full.
- `protoErr`  out  1  sticky: an illegal export sequence was detected.

## Operation
- Assembly FSM, 2 states.
  - WaitHi (reset state): on `done&selL&~selR`, capture `dataBus` into the `hiReg` holding register and go to WaitLo.
  - WaitLo: on `done&selR&~selL`, form `{hiReg, dataBus}`, issue a push, and go to WaitHi.
- Illegal events. Each one sets `protoErr`. None of them pushes.
  - `done` with `selL=selR=1`, in either state: ignored, state unchanged.
  - `done&selR` in WaitHi: ignored, stay in WaitHi.
  - `done&selL` in WaitLo: treated as a restart. `hiReg` is reloaded and the FSM stays in WaitLo.
  - `done` with `selL=selR=0`: ignored.
- `selL`/`selR` without `done` are ignored and are not errors.
- Push into a full FIFO:
  - If a pop happens in the same cycle, the push is accepted.
  - Otherwise the product is dropped, `overflow` is set, and the FSM still returns to WaitHi.
- Pop occurs when `outValid&outReady`. The read pointer advances.
- Push with no pop: `count`+1. Pop with no push: `count`−1. Both in the same cycle: `count` unchanged.
- Pointers wrap modulo DEPTH.
- No arithmetic is performed; halves are concatenated bit-exact, so sign is preserved.
- `clrErr` clears both sticky flags. If a set condition occurs in the same cycle, set wins.

## Timing
- Reset (`rst`=0, asynchronous):
  - FSM goes to WaitHi.
  - `hiReg`, both pointers and `count` go to 0.
  - `outValid`, `full`, `overflow`, `protoErr` and `outProduct` all go to 0.
- Latency: the product appears on `outProduct` with `outValid`=1 on the clock edge ending the `selR` cycle. This is 1 cycle after the low-half export, with no bypass into an empty FIFO.
- `outProduct`/`outValid` are stable while `outValid&~outReady`, per valid/ready rules.
- `full` updates on the same edge as `count`. Upstream samples `full` before asserting `start`.
- Reset mid-export (between the `selL` and `selR` cycles): the partial high half is discarded and no push occurs.

## Structure
- Shared package `booth_pkg`:
  - FSM state encoding localparams (`WAIT_HI`, `WAIT_LO`).
  - The default `WIDTH`, shared with the multiplier.
- One sub-module, `sync_fifo`:
  - Parameters: data width, `DEPTH`.
  - Ports: push, pop, data in/out, `count`, `full`, `empty`.
  - The collector instantiates it with data width 2·WIDTH.

## Test plan
- Basic export (WIDTH=8). Drive `done&selL` with bus 8'hFF, then `done&selR` with bus 8'hF1, with `outReady`=1. Required: next cycle `outValid`=1 and `outProduct`=16'hFFF1 (−15). `protoErr`=0 and `overflow`=0.
- Fill and overflow. With `outReady`=0, perform 5 exports with products 16'h0001 to 16'h0005. Required:
  - `full`=1 after the 4th export, `count`=4, `overflow`=1.
  - Draining yields 0001, 0002, 0003, 0004 in order.
- Full with simultaneous pop. With the FIFO full, hold `outReady`=1 during the `selR` cycle. Required: the push is accepted, `count` stays 4, `overflow` stays 0, and the new product appears 4th in drain order.
- Protocol errors:
  - `done&selR` alone in WaitHi: `protoErr`=1 and no push.
  - `selL` bus 8'hAA, then `selL` bus 8'h12, then `selR` bus 8'h34: output is 16'h1234.
  - `clrErr` clears `protoErr`.
- Reset mid-export. Assert `rst`=0 after the `selL` cycle, release it, then complete a full export of 16'h0A0B. Required: only 16'h0A0B is delivered and all flags are 0.
- Random back-pressure. Run 200 random products with random `outReady`. Required: the output stream equals the input stream exactly, and `count` never exceeds 4.
